// File: rtl/reg_bank_arbiter_pkg.sv
// Shared types and sizes for the two-requester register bank arbiter and its bench.
// Holds the FSM encoding, default dimensions and the write-counter width.
package reg_bank_arbiter_pkg;

   localparam int WIDTH_DEF = 8;
   localparam int DEPTH_DEF = 4;
   localparam int ADDR_W    = 2;
   localparam int CNT_W     = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      ACK   = 2'd2
   } state_t;

   // Lone requester wins outright; on contention the round-robin pointer decides.
   function automatic logic pick_winner(input logic r0, input logic r1, input logic rr);
      return (r0 && r1) ? rr : ~r0;
   endfunction

endpackage

// File: rtl/reg_bank_arbiter_if.sv
// Requester, read-port and status signals of the register bank arbiter.
// Master drives requests and read index; slave returns grants, read data and status.
interface reg_bank_arbiter_if #(
   parameter int WIDTH = reg_bank_arbiter_pkg::WIDTH_DEF
);
   import reg_bank_arbiter_pkg::*;

   logic              req0;
   logic [ADDR_W-1:0] addr0;
   logic [WIDTH-1:0]  data0;
   logic              req1;
   logic [ADDR_W-1:0] addr1;
   logic [WIDTH-1:0]  data1;
   logic              gnt0;
   logic              gnt1;
   logic [ADDR_W-1:0] rd_addr;
   logic [WIDTH-1:0]  rd_data;
   logic              busy;
   logic [CNT_W-1:0]  wr_count;

   modport master (
      output req0, addr0, data0, req1, addr1, data1, rd_addr,
      input  gnt0, gnt1, rd_data, busy, wr_count
   );

   modport slave (
      input  req0, addr0, data0, req1, addr1, data1, rd_addr,
      output gnt0, gnt1, rd_data, busy, wr_count
   );

endinterface

// File: rtl/reg_bank.sv
// DEPTH x WIDTH register file: synchronous clear and write, combinational read.
// Write lands at the clock edge; clear overrides any write in the same cycle.
module reg_bank #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] regs [DEPTH];

   always_ff @(posedge clk) begin
      if (clear) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_en) begin
         regs[wr_addr] <= wr_data;
      end
   end

   assign rd_data = regs[rd_addr];

endmodule

// File: rtl/reg_bank_arbiter.sv
// Round-robin arbiter for two four-phase writers into a register bank; grant two edges after request.
// While busy, new requests are held off until IDLE; the winner keeps its grant until it drops req.
module reg_bank_arbiter
   import reg_bank_arbiter_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic              clk,
   input  logic              clear,
   reg_bank_arbiter_if.slave bus
);

   state_t            state;
   state_t            next_state;
   logic              sel;
   logic              rr;
   logic              win;
   logic              sel_req;
   logic              wr_en;
   logic              gnt0;
   logic              gnt1;
   logic [ADDR_W-1:0] lat_addr;
   logic [WIDTH-1:0]  lat_data;
   logic [WIDTH-1:0]  rd_data;
   logic [CNT_W-1:0]  wr_count;

   assign win     = pick_winner(bus.req0, bus.req1, rr);
   assign sel_req = sel ? bus.req1 : bus.req0;
   assign wr_en   = (state == WRITE);

   always_ff @(posedge clk) begin
      if (clear) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (bus.req0 || bus.req1) next_state = WRITE;
         WRITE:   next_state = ACK;
         ACK:     if (!sel_req) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Grants follow the next state so they coincide exactly with the ACK cycles.
   always_ff @(posedge clk) begin
      if (clear) begin
         sel      <= 1'b0;
         rr       <= 1'b0;
         lat_addr <= '0;
         lat_data <= '0;
         gnt0     <= 1'b0;
         gnt1     <= 1'b0;
         wr_count <= '0;
      end else begin
         if (state == IDLE && (bus.req0 || bus.req1)) begin
            sel      <= win;
            rr       <= ~win;
            lat_addr <= win ? bus.addr1 : bus.addr0;
            lat_data <= win ? bus.data1 : bus.data0;
         end
         if (state == WRITE) begin
            wr_count <= wr_count + 1'b1;
         end
         gnt0 <= (next_state == ACK) && !sel;
         gnt1 <= (next_state == ACK) && sel;
      end
   end

   reg_bank #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (ADDR_W)
   ) u_bank (
      .clk     (clk),
      .clear   (clear),
      .wr_en   (wr_en),
      .wr_addr (lat_addr),
      .wr_data (lat_data),
      .rd_addr (bus.rd_addr),
      .rd_data (rd_data)
   );

   assign bus.gnt0     = gnt0;
   assign bus.gnt1     = gnt1;
   assign bus.rd_data  = rd_data;
   assign bus.busy     = (state != IDLE);
   assign bus.wr_count = wr_count;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Bench for reg_bank_arbiter: transaction-level model compared every cycle, plus directed literal checks.
module tb_reg_bank_arbiter;
   import reg_bank_arbiter_pkg::*;

   logic clk = 1'b0;
   logic clear;
   always #5 clk = ~clk;

   reg_bank_arbiter_if bus ();

   reg_bank_arbiter dut (
      .clk   (clk),
      .clear (clear),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: one outstanding transaction with an owner and its age in cycles since acceptance.
   logic [7:0] m_bank [4];
   int   m_count = 0;
   int   m_rr    = 0;
   int   m_owner = -1;
   int   m_age   = 0;
   int   m_addr  = 0;
   logic [7:0] m_data;
   bit   model_on = 1'b0;

   always @(posedge clk) begin
      if (clear) begin
         for (int i = 0; i < 4; i++) m_bank[i] = 8'h00;
         m_count  = 0;
         m_rr     = 0;
         m_owner  = -1;
         m_age    = 0;
         model_on = 1'b1;
      end else if (model_on) begin
         if (m_owner < 0) begin
            if (bus.req0 || bus.req1) begin
               if (bus.req0 && bus.req1) m_owner = m_rr;
               else m_owner = bus.req0 ? 0 : 1;
               m_rr   = 1 - m_owner;
               m_addr = (m_owner == 0) ? int'(bus.addr0) : int'(bus.addr1);
               m_data = (m_owner == 0) ? bus.data0 : bus.data1;
               m_age  = 0;
            end
         end else if (m_age == 0) begin
            m_bank[m_addr] = m_data;
            m_count = (m_count + 1) % 256;
            m_age   = 1;
         end else if (!((m_owner == 0) ? bus.req0 : bus.req1)) begin
            m_owner = -1;
         end
      end
   end

   int   grant_q [$];
   bit   prev_g0 = 1'b0;
   bit   prev_g1 = 1'b0;
   bit   gnt1_seen = 1'b0;
   int   g0_cycles = 0;

   always @(negedge clk) begin
      if (model_on) begin
         check("gnt0",     bus.gnt0, (m_owner == 0 && m_age == 1));
         check("gnt1",     bus.gnt1, (m_owner == 1 && m_age == 1));
         check("busy",     bus.busy, (m_owner >= 0));
         check("wr_count", bus.wr_count, m_count);
         check("rd_data",  bus.rd_data, m_bank[bus.rd_addr]);
         check("gnt_excl", bus.gnt0 & bus.gnt1, 0);
      end
      if (bus.gnt0 && !prev_g0) grant_q.push_back(0);
      if (bus.gnt1 && !prev_g1) grant_q.push_back(1);
      if (bus.gnt1) gnt1_seen = 1'b1;
      if (bus.gnt0) g0_cycles++;
      prev_g0 = bus.gnt0;
      prev_g1 = bus.gnt1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   task automatic wait_any_gnt(input string name);
      bit got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (bus.gnt0 || bus.gnt1) begin
            got = 1'b1;
            break;
         end
         tick();
      end
      check(name, got, 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      clear = 1'b1;
      bus.req0 = 1'b0; bus.addr0 = '0; bus.data0 = '0;
      bus.req1 = 1'b0; bus.addr1 = '0; bus.data1 = '0;
      bus.rd_addr = '0;
      repeat (2) tick();
      clear = 1'b0;
      check("rst_busy",  bus.busy, 0);
      check("rst_count", bus.wr_count, 0);
      check("rst_gnt",   {bus.gnt1, bus.gnt0}, 0);
      check("rst_rd",    bus.rd_data, 0);

      // Single write with inputs changing after the arbitration edge.
      bus.req0 = 1'b1; bus.addr0 = 2'd2; bus.data0 = 8'hA5; bus.rd_addr = 2'd2;
      tick();
      bus.addr0 = 2'd0; bus.data0 = 8'h5A;
      check("single_gnt_early", bus.gnt0, 0);
      check("single_busy",      bus.busy, 1);
      tick();
      check("single_gnt",   bus.gnt0, 1);
      check("single_rd",    bus.rd_data, 8'hA5);
      check("single_count", bus.wr_count, 1);
      tick();
      check("single_hold",  bus.gnt0, 1);
      bus.req0 = 1'b0;
      tick();
      check("single_drop",  bus.gnt0, 0);
      check("single_idle",  bus.busy, 0);
      bus.rd_addr = 2'd0;
      check("single_ignored_addr", bus.rd_data, 8'h00);

      // Simultaneous requests right after a clear: requester 0 first.
      pulse_clear();
      grant_q.delete();
      bus.req0 = 1'b1; bus.addr0 = 2'd1; bus.data0 = 8'h11;
      bus.req1 = 1'b1; bus.addr1 = 2'd1; bus.data1 = 8'h22;
      bus.rd_addr = 2'd1;
      wait_any_gnt("sim_first_wait");
      tick();
      bus.req0 = 1'b0;
      tick();
      wait_any_gnt("sim_second_wait");
      tick();
      bus.req1 = 1'b0;
      repeat (2) tick();
      check("sim_ngrants", grant_q.size(), 2);
      if (grant_q.size() == 2) begin
         check("sim_order0", grant_q[0], 0);
         check("sim_order1", grant_q[1], 1);
      end
      check("sim_bank1", bus.rd_data, 8'h22);
      check("sim_count", bus.wr_count, 2);

      // Fairness: both held, each released one cycle after its grant and reasserted.
      pulse_clear();
      grant_q.delete();
      bus.req0 = 1'b1; bus.addr0 = 2'd0; bus.data0 = 8'h30;
      bus.req1 = 1'b1; bus.addr1 = 2'd3; bus.data1 = 8'h40;
      for (int k = 0; k < 4; k++) begin
         wait_any_gnt("fair_wait");
         if (bus.gnt1) begin
            tick();
            bus.req1 = 1'b0;
            tick();
            bus.data1 = bus.data1 + 8'd1;
            if (k < 3) bus.req1 = 1'b1;
         end else begin
            tick();
            bus.req0 = 1'b0;
            tick();
            bus.data0 = bus.data0 + 8'd1;
            if (k < 3) bus.req0 = 1'b1;
         end
      end
      bus.req0 = 1'b0; bus.req1 = 1'b0;
      repeat (3) tick();
      check("fair_ngrants", grant_q.size(), 4);
      if (grant_q.size() == 4) begin
         check("fair_g0", grant_q[0], 0);
         check("fair_g1", grant_q[1], 1);
         check("fair_g2", grant_q[2], 0);
         check("fair_g3", grant_q[3], 1);
      end
      check("fair_count", bus.wr_count, 4);

      // Clear during WRITE aborts the pending write.
      pulse_clear();
      gnt1_seen = 1'b0;
      bus.req1 = 1'b1; bus.addr1 = 2'd3; bus.data1 = 8'hFF; bus.rd_addr = 2'd3;
      tick();
      clear = 1'b1; bus.req1 = 1'b0;
      tick();
      clear = 1'b0;
      repeat (2) tick();
      check("abort_bank3", bus.rd_data, 8'h00);
      check("abort_count", bus.wr_count, 0);
      check("abort_nognt", gnt1_seen, 0);
      check("abort_busy",  bus.busy, 0);

      // Early-drop writes, 256 of them, wrapping the counter.
      pulse_clear();
      for (int n = 0; n < 256; n++) begin
         if (n == 0) g0_cycles = 0;
         bus.req0 = 1'b1; bus.addr0 = 2'(n % 4); bus.data0 = 8'(n);
         bus.rd_addr = 2'((n + 1) % 4);
         tick();
         bus.req0 = 1'b0;
         repeat (2) tick();
         if (n == 0) check("early_gnt_cycles", g0_cycles, 1);
         if (n == 0) check("early_count", bus.wr_count, 1);
      end
      check("wrap_count", bus.wr_count, 0);
      bus.rd_addr = 2'd3;
      #1 check("wrap_bank3", bus.rd_data, 8'hFF);
      bus.rd_addr = 2'd0;
      #1 check("wrap_bank0", bus.rd_data, 8'hFC);

      repeat (2) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
